// File: rtl/cs_pkg.sv
// Shared widths, word types and FSM encoding for the cs_resolve carry-save resolver.
package cs_pkg;

    localparam int unsigned COL_W   = 25;
    localparam int unsigned DIG_W   = 17;
    localparam int unsigned CARRY_W = COL_W + 2 - DIG_W;

    typedef logic [COL_W-1:0]   col_t;
    typedef logic [DIG_W-1:0]   dig_t;
    typedef logic [CARRY_W-1:0] carry_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } cs_state_t;

endpackage

// File: rtl/cs_resolve_add.sv
// Combinational three-input add of carry word, sum word and running carry,
// split into the emitted digit and the carry into the next column.
module cs_resolve_add
    import cs_pkg::*;
#(
    parameter int unsigned COL_W = 25,
    parameter int unsigned DIG_W = 17
) (
    input  logic [COL_W-1:0]       i_c,
    input  logic [COL_W-1:0]       i_s,
    input  logic [COL_W+1-DIG_W:0] i_carry,
    output logic [DIG_W-1:0]       o_digit,
    output logic [COL_W+1-DIG_W:0] o_carry
);

    logic [COL_W+1:0] w_sum;

    always_comb begin
        w_sum   = (COL_W+2)'(i_c) + (COL_W+2)'(i_s) + (COL_W+2)'(i_carry);
        o_digit = w_sum[DIG_W-1:0];
        o_carry = w_sum[COL_W+1:DIG_W];
    end

endmodule

// File: rtl/cs_resolve.sv
// Resolves a stream of carry-save columns into digits plus one flush digit per frame.
// Optional out_ovf port enabled by defining CS_RESOLVE_OVF_EN.
module cs_resolve
    import cs_pkg::*;
#(
    parameter int unsigned COL_W = 25,
    parameter int unsigned DIG_W = 17
) (
    input  logic             clk_sq,
    input  logic             reset_sq,
    input  logic [COL_W-1:0] in_c,
    input  logic [COL_W-1:0] in_s,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    output logic [DIG_W-1:0] out_digit,
    output logic             out_valid,
`ifdef CS_RESOLVE_OVF_EN
    output logic             out_ovf,
`endif
    input  logic             out_ready,
    output logic             out_last
);

    localparam int unsigned CW = COL_W + 2 - DIG_W;

    cs_state_t        r_state;
    logic [CW-1:0]    r_carry;
    logic [DIG_W-1:0] r_digit;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_ovf;

    logic [DIG_W-1:0] w_digit;
    logic [CW-1:0]    w_carry;
    logic             w_out_free;
    logic             w_accept;

    cs_resolve_add #(
        .COL_W (COL_W),
        .DIG_W (DIG_W)
    ) u_add (
        .i_c     (in_c),
        .i_s     (in_s),
        .i_carry (r_carry),
        .o_digit (w_digit),
        .o_carry (w_carry)
    );

    // in_ready depends only on registered state and out_ready, never on in_valid
    assign w_out_free = !r_out_valid || out_ready;
    assign in_ready   = !reset_sq && (r_state != FLUSH) && w_out_free;
    assign w_accept   = in_valid && in_ready;

    always_ff @(posedge clk_sq) begin
        if (reset_sq) begin
            r_state     <= IDLE;
            r_carry     <= '0;
            r_digit     <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                IDLE, RUN: begin
                    if (w_accept) begin
                        r_digit     <= w_digit;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_carry     <= w_carry;
                        r_state     <= in_last ? FLUSH : RUN;
                    end
                end
                FLUSH: begin
                    if (w_out_free) begin
                        r_digit     <= DIG_W'(r_carry);
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b1;
                        r_ovf       <= (r_carry != '0);
                        r_carry     <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_digit = r_digit;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

`ifdef CS_RESOLVE_OVF_EN
    assign out_ovf = r_ovf;
`else
    logic w_ovf_unused;
    assign w_ovf_unused = r_ovf;
`endif

endmodule

// File: tb/tb_cs_resolve.sv
// Directed self-checking bench for cs_resolve; digits are captured by a monitor and
// compared against hand-computed frames.
module tb_cs_resolve;

    logic        clk_sq = 1'b0;
    logic        reset_sq;
    logic [24:0] in_c;
    logic [24:0] in_s;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [16:0] out_digit;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        w_ovf;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned n_ovf_ign = 0;
    logic [31:0] q[$];

    always #5 clk_sq = ~clk_sq;

    cs_resolve #(
        .COL_W (25),
        .DIG_W (17)
    ) dut (
        .clk_sq    (clk_sq),
        .reset_sq  (reset_sq),
        .in_c      (in_c),
        .in_s      (in_s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .out_digit (out_digit),
        .out_valid (out_valid),
`ifdef CS_RESOLVE_OVF_EN
        .out_ovf   (w_ovf),
`endif
        .out_ready (out_ready),
        .out_last  (out_last)
    );

`ifndef CS_RESOLVE_OVF_EN
    assign w_ovf = 1'b0;
`endif

    // Inputs change #1 after posedge, so a handshake seen at negedge completes at the next posedge
    always @(negedge clk_sq) begin
        if (!reset_sq && out_valid && out_ready)
            q.push_back({13'b0, w_ovf, out_last, out_digit});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_col(input logic [24:0] c, input logic [24:0] s, input logic last,
                            output int unsigned stalls);
        in_c     = c;
        in_s     = s;
        in_last  = last;
        in_valid = 1'b1;
        stalls   = 0;
        forever begin
            @(negedge clk_sq);
            if (in_ready) break;
            stalls++;
            if (stalls > 50) begin
                check("send_timeout", stalls, 0);
                break;
            end
        end
        @(posedge clk_sq);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_q(input string tag, input int unsigned n);
        for (int i = 0; i < 60 && q.size() < n; i++) @(posedge clk_sq);
        #1;
        check({tag, "_count"}, q.size(), n);
    endtask

    task automatic expect_dig(input string tag, input logic [16:0] d, input logic l, input logic o);
        logic [31:0] e;
        if (q.size() == 0) begin
            check({tag, "_present"}, 0, 1);
            return;
        end
        e = q.pop_front();
        check({tag, "_dig"}, {15'b0, e[16:0]}, {15'b0, d});
        check({tag, "_last"}, {31'b0, e[17]}, {31'b0, l});
`ifdef CS_RESOLVE_OVF_EN
        check({tag, "_ovf"}, {31'b0, e[18]}, {31'b0, o});
`else
        if (o) n_ovf_ign++;
`endif
    endtask

    initial begin
        int unsigned st;
        reset_sq  = 1'b1;
        in_valid  = 1'b0;
        in_c      = '0;
        in_s      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // reset state
        repeat (2) @(posedge clk_sq);
        @(negedge clk_sq);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_digit", {15'b0, out_digit}, 0);
        check("rst_out_last",  {31'b0, out_last}, 0);
        check("rst_in_ready",  {31'b0, in_ready}, 0);
        @(posedge clk_sq);
        #1 reset_sq = 1'b0;

        // single-column frame with carry out
        send_col(25'h1FFFFFF, 25'h0000001, 1'b1, st);
        wait_q("single", 2);
        expect_dig("single_d0", 17'h00000, 1'b0, 1'b0);
        expect_dig("single_fl", 17'h00100, 1'b1, 1'b1);

        // three-column frame
        send_col(25'h1FFFF, 25'h1,     1'b0, st);
        send_col(25'h0,     25'h0,     1'b0, st);
        send_col(25'h1FFFF, 25'h1FFFF, 1'b1, st);
        wait_q("three", 4);
        expect_dig("three_d0", 17'h00000, 1'b0, 1'b0);
        expect_dig("three_d1", 17'h00001, 1'b0, 1'b0);
        expect_dig("three_d2", 17'h1FFFE, 1'b0, 1'b0);
        expect_dig("three_fl", 17'h00001, 1'b1, 1'b1);

        // downstream stall for 3 cycles with the next column already offered
        @(posedge clk_sq);
        #1;
        out_ready = 1'b0;
        in_c = 25'h5; in_s = 25'h3; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk_sq);
        check("stall_ready_pre", {31'b0, in_ready}, 1);
        @(posedge clk_sq);
        #1;
        in_c = 25'h10; in_s = 25'h0; in_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_sq);
            check("stall_valid", {31'b0, out_valid}, 1);
            check("stall_digit", {15'b0, out_digit}, 32'h8);
            check("stall_in_ready", {31'b0, in_ready}, 0);
            @(posedge clk_sq);
            #1;
        end
        out_ready = 1'b1;
        st = 0;
        forever begin
            @(negedge clk_sq);
            if (in_ready || st > 50) break;
            st++;
        end
        check("stall_release", {31'b0, in_ready}, 1);
        @(posedge clk_sq);
        #1 in_valid = 1'b0;
        wait_q("stall", 3);
        expect_dig("stall_d0", 17'h00008, 1'b0, 1'b0);
        expect_dig("stall_d1", 17'h00010, 1'b0, 1'b0);
        expect_dig("stall_fl", 17'h00000, 1'b1, 1'b0);

        // reset mid-frame with a pending carry
        send_col(25'h1FFFF, 25'h1,     1'b0, st);
        send_col(25'h1FFFF, 25'h1FFFF, 1'b0, st);
        wait_q("abort", 2);
        expect_dig("abort_d0", 17'h00000, 1'b0, 1'b0);
        expect_dig("abort_d1", 17'h1FFFF, 1'b0, 1'b0);
        @(posedge clk_sq);
        #1 reset_sq = 1'b1;
        @(negedge clk_sq);
        check("abort_rst_valid", {31'b0, out_valid}, 0);
        check("abort_rst_ready", {31'b0, in_ready}, 0);
        @(posedge clk_sq);
        #1 reset_sq = 1'b0;
        send_col(25'h1, 25'h1, 1'b1, st);
        wait_q("post_rst", 2);
        repeat (5) @(posedge clk_sq);
        #1;
        check("post_rst_no_extra", q.size(), 2);
        expect_dig("post_rst_d0", 17'h00002, 1'b0, 1'b0);
        expect_dig("post_rst_fl", 17'h00000, 1'b1, 1'b0);

        // back-to-back single-column frames
        send_col(25'h2, 25'h3, 1'b1, st);
        check("b2b_first_stall", st, 0);
        send_col(25'h1FFFF, 25'h1FFFF, 1'b1, st);
        check("b2b_second_stall", st, 1);
        wait_q("b2b", 4);
        expect_dig("b2b_d0", 17'h00005, 1'b0, 1'b0);
        expect_dig("b2b_f0", 17'h00000, 1'b1, 1'b0);
        expect_dig("b2b_d1", 17'h1FFFE, 1'b0, 1'b0);
        expect_dig("b2b_f1", 17'h00001, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got expired expected finish");
        $fatal(1);
    end

endmodule

// File: doc/cs_resolve.md
CS_RESOLVE -- requirements
Module: cs_resolve

Interface
REQ-001 Parameter COL_W, default 25, width of each carry-save column word.
REQ-002 Parameter DIG_W, default 17, width of each resolved output digit.
REQ-003 clk_sq  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_sq  input  1  reset, synchronous and active-high.
REQ-005 in_c  input  COL_W  carry word of the current column, pre-shifted by the producer.
REQ-006 in_s  input  COL_W  sum word of the current column.
REQ-007 in_valid / in_ready  input / output  1 each  column handshake; transfer when both are high.
REQ-008 in_last  input  1  qualifies the final column of a frame.
REQ-009 out_digit  output  DIG_W  resolved digit, least significant first.
REQ-010 out_valid / out_ready  output / input  1 each  digit handshake.
REQ-011 out_last  output  1  marks the final digit of a frame.

Function
REQ-012 The block SHALL compute sum = in_c + in_s + carry_q per accepted column, using width COL_W+2 (27 bits at defaults).
REQ-013 It SHALL emit out_digit = sum[DIG_W-1:0] and load carry_q = sum >> DIG_W; carry_q is COL_W+2-DIG_W bits (10 bits at defaults).
REQ-014 The output stage SHALL be a single registered entry; a column accepted in cycle N appears on out_digit in cycle N+1.
REQ-015 in_ready SHALL equal (state != FLUSH) && (!out_valid || out_ready), with no combinational path from in_valid.
REQ-016 out_valid, out_digit and out_last SHALL hold stable while out_valid && !out_ready.
REQ-017 FSM states: IDLE (carry_q = 0, no frame open), RUN (frame open), FLUSH (last column accepted, carry digit pending).
REQ-018 Transitions:
- IDLE->RUN on a column accepted without in_last.
- IDLE->FLUSH or RUN->FLUSH on a column accepted with in_last.
- FLUSH->IDLE when the flush digit is loaded into the output register.
REQ-019 In FLUSH, the block SHALL load out_digit = zero-extended carry_q with out_last = 1 as soon as the output register is free, then clear carry_q.
REQ-020 Every frame SHALL produce exactly (columns + 1) digits; out_last is asserted only on the flush digit, including when carry_q = 0.
REQ-021 A single-column frame (in_last on the first column) SHALL be legal and yield 2 digits.
REQ-022 Back-to-back frames SHALL be accepted with no idle cycle beyond the single FLUSH cycle.

Reset
REQ-023 While reset_sq is high, the block SHALL drive out_valid = 0, out_digit = 0, out_last = 0, carry_q = 0, state = IDLE and in_ready = 0.
REQ-024 Reset mid-frame SHALL discard the partial frame and any pending digit; the first column after reset starts a new frame.

Configuration
REQ-025 With CS_RESOLVE_OVF_EN defined, the block SHALL add output port out_ovf (1 bit), registered alongside out_digit; out_ovf = 1 on the flush digit if carry_q != 0, otherwise 0, and out_ovf resets to 0.
REQ-026 Without CS_RESOLVE_OVF_EN, the out_ovf port and its logic SHALL be absent, with all other behaviour unchanged.

Structure
REQ-027 Package cs_pkg SHALL hold:
- localparams COL_W = 25, DIG_W = 17, CARRY_W = COL_W + 2 - DIG_W;
- typedef col_t, dig_t, carry_t;
- enum cs_state_t {IDLE, RUN, FLUSH}.
REQ-028 One sub-module, cs_resolve_add, SHALL implement the combinational three-input add and digit/carry split; the FSM and registers stay in cs_resolve.

Verification
REQ-029 Single column in_c = 0x1FFFFFF, in_s = 0x0000001, in_last = 1 -> digit 0x00000, then flush digit 0x00100 with out_last = 1 (out_ovf = 1 if enabled).
REQ-030 Three columns (C,S) = (0x1FFFF, 1), (0, 0), (0x1FFFF, 0x1FFFF) with last on the third -> digits 0x00000, 0x00001, 0x1FFFE, then flush 0x00001 with out_last = 1.
REQ-031 out_ready held low for 3 cycles while a digit is pending -> out_digit stable, in_ready = 0 for those cycles, no column lost, correct sequence afterwards.
REQ-032 reset_sq pulsed for 1 cycle after 2 columns of a 4-column frame -> no further digits from that frame; the next frame (1, 1, last) yields 0x00002 then 0x00000.
REQ-033 Two back-to-back single-column frames with out_ready tied high -> 4 digits, out_last on the 2nd and 4th, one in_ready-low cycle between frames.
